serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 135 +++++++++++++
 tb/tb_serial_subtractor.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: LSB-first full-subtractor chain,
// one result bit per clock, WIDTH+2 cycles per operation.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic             load;
    logic             d_bit;
    logic             br_nx;

    // One-bit full subtractor on the operand LSBs and the running borrow.
    always_comb begin
        d_bit = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
        br_nx = (~a_sh_q[0] & b_sh_q[0])
              | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);
    end

    // Next-state and datapath; the DONE exit edge is also the
    // first edge at which a new start can be taken.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        done_d   = 1'b0;
        busy_d   = busy_q;
        load     = 1'b0;

        unique case (state_q)
            IDLE: begin
                load = start;
            end
            RUN: begin
                if (cnt_q == CW'(WIDTH)) begin
                    diff_d   = res_q;
                    borrow_d = br_q;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else begin
                    a_sh_d = a_sh_q >> 1;
                    b_sh_d = b_sh_q >> 1;
                    res_d  = (res_q >> 1)
                           | (WIDTH'(d_bit) << (WIDTH - 1));
                    br_d   = br_nx;
                    cnt_d  = cnt_q + CW'(1);
                end
            end
            DONE: begin
                load    = start;
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (load) begin
            a_sh_d  = a;
            b_sh_d  = b;
            res_d   = '0;
            br_d    = 1'b0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = RUN;
        end
    end

    // State and registered outputs, all cleared by async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: WIDTH=8 vector table, corner
// sequences (back-to-back, mid-run reset) and a WIDTH=1 instance.
`timescale 1ns/1ps
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a, b;
    logic       busy, done, borrow_out;
    logic [7:0] diff;

    logic       start1;
    logic       a1, b1;
    logic       busy1, done1, borrow1;
    logic       diff1;

    int n_chk  = 0;
    int n_fail = 0;
    logic [7:0] last_diff;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a(a), .b(b), .busy(busy), .done(done),
        .diff(diff), .borrow_out(borrow_out)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .a(a1), .b(b1), .busy(busy1), .done(done1),
        .diff(diff1), .borrow_out(borrow1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] diff;
        logic       bor;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] f(input int i);
        return 8'(i * 37 + 11);
    endfunction

    // One WIDTH=8 operation; operands scrambled after acceptance.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_,
                          input logic [7:0] ed, input logic eb);
        int  lat;
        bit  got;
        @(negedge clk);
        a = ta; b = tb_; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~ta; b = tb_ ^ 8'h5A;
        check("busy_after_start", 32'(busy), 32'd1);
        lat = 0; got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == 5)
                check("diff_hold_in_run", 32'(diff), 32'(last_diff));
            if (done) got = 1'b1;
        end
        check("done_seen", 32'(got), 32'd1);
        check("done_latency", lat, 32'd9);
        check("diff", 32'(diff), 32'(ed));
        check("borrow", 32'(borrow_out), 32'(eb));
        last_diff = ed;
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_clear", 32'(busy), 32'd0);
    endtask

    task automatic run1(input logic ta, input logic tb_,
                        input logic ed, input logic eb);
        int lat;
        bit got;
        @(negedge clk);
        a1 = ta; b1 = tb_; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; a1 = ~ta; b1 = ~tb_;
        lat = 0; got = 1'b0;
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            if (done1) got = 1'b1;
        end
        check("w1_done_seen", 32'(got), 32'd1);
        check("w1_latency", lat, 32'd2);
        check("w1_diff", 32'(diff1), 32'(ed));
        check("w1_borrow", 32'(borrow1), 32'(eb));
        @(negedge clk);
        check("w1_busy_clear", 32'(busy1), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
        vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1};
        vecs[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
        vecs[4] = '{8'h10, 8'h01, 8'h0F, 1'b0};
        vecs[5] = '{8'h80, 8'h7F, 8'h01, 1'b0};
        vecs[6] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vecs[7] = '{8'h7F, 8'h80, 8'hFF, 1'b1};
        vecs[8] = '{8'hA5, 8'h5A, 8'h4B, 1'b0};

        rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        last_diff = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow_out), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].bor);

        // Start held high: accepts every 10 edges, a changes each cycle.
        for (int i = 0; i < 40; i++) begin
            a = f(i); b = 8'h02;
            start = (i <= 30);
            @(posedge clk);
            @(negedge clk);
            check("b2b_busy", 32'(busy), 32'd1);
            check("b2b_done", 32'(done), 32'((i % 10) == 9));
            if ((i % 10) == 9) begin
                check("b2b_diff", 32'(diff), 32'(f(i - 9) - 8'h02));
                last_diff = f(i - 9) - 8'h02;
            end
        end
        start = 1'b0;
        @(negedge clk);
        check("b2b_idle", 32'(busy), 32'd0);

        // Reset three cycles into RUN.
        @(negedge clk);
        a = 8'h33; b = 8'h11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_diff", 32'(diff), 32'd0);
        check("mid_rst_borrow", 32'(borrow_out), 32'd0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1'b1;
            check("mid_rst_no_done", 32'(done), 32'd0);
        end
        last_diff = 8'h00;
        run_op(8'h10, 8'h01, 8'h0F, 1'b0);

        run1(1'b0, 1'b0, 1'b0, 1'b0);
        run1(1'b1, 1'b0, 1'b1, 1'b0);
        run1(1'b0, 1'b1, 1'b1, 1'b1);
        run1(1'b1, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
